// File: rtl/fetch_stage.sv
// RV32I IF stage: owns the fetch PC, runs a one-outstanding req/gnt/rvalid fetch and fills IF/ID.
// Optional macro FETCH_MISALIGN_TRAP_EN adds fetch_misalign and a terminal trap state on misaligned redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  PC_sel,
    input  logic        flush,
    input  logic [31:0] branch_target,
    input  logic [31:0] jalr_target,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instr,
    output logic [31:0] IF_ID_pc,
    output logic [31:0] IF_ID_pc4,
    output logic        IF_ID_valid
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fetch_misalign
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [1:0] S_TRAP = 2'd3;
`endif

    logic [1:0]  r_state, w_state_nxt;
    logic        r_req;
    logic [31:0] r_pc, w_pc_nxt;
    logic [31:0] r_issue_pc, w_issue_pc_nxt;
    logic        r_discard, w_discard_nxt;
    logic [31:0] r_hold_instr, w_hold_instr_nxt;
    logic [31:0] r_ifid_instr, w_ifid_instr_nxt;
    logic [31:0] r_ifid_pc, w_ifid_pc_nxt;
    logic [31:0] r_ifid_pc4, w_ifid_pc4_nxt;
    logic        r_ifid_valid, w_ifid_valid_nxt;
    logic [31:0] w_target_raw;
    logic [31:0] w_target;
    logic        w_granted;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        r_misalign, w_misalign_nxt;
    logic        w_redirect;
`endif

    // Redirect target; PC_sel=00 keeps the current PC so a bare flush only squashes.
    always_comb begin
        case (PC_sel)
            2'b01, 2'b10: w_target_raw = branch_target;
            2'b11:        w_target_raw = jalr_target & ~32'h0000_0001;
            default:      w_target_raw = r_pc;
        endcase
    end

    assign w_target  = w_target_raw & 32'hFFFF_FFFC;
    assign w_granted = r_req && imem_gnt;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign w_redirect = flush && (PC_sel != 2'b00);
`endif

    // Next-state logic for the fetch FSM, hold buffer and IF/ID register.
    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_issue_pc_nxt   = r_issue_pc;
        w_discard_nxt    = r_discard;
        w_hold_instr_nxt = r_hold_instr;
        w_ifid_instr_nxt = r_ifid_instr;
        w_ifid_pc_nxt    = r_ifid_pc;
        w_ifid_pc4_nxt   = r_ifid_pc4;
        w_ifid_valid_nxt = r_ifid_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        w_misalign_nxt   = r_misalign;
`endif
        if (flush) begin
            w_ifid_instr_nxt = NOP_INSTR;
            w_ifid_pc_nxt    = 32'h0000_0000;
            w_ifid_pc4_nxt   = 32'h0000_0000;
            w_ifid_valid_nxt = 1'b0;
            w_pc_nxt         = w_target;
            case (r_state)
                S_REQ: begin
                    // A request granted on the flush edge returns stale data.
                    if (w_granted) begin
                        w_state_nxt   = S_WAIT;
                        w_discard_nxt = 1'b1;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        w_state_nxt   = S_REQ;
                        w_discard_nxt = 1'b0;
                    end else begin
                        w_discard_nxt = 1'b1;
                    end
                end
                S_HOLD:  w_state_nxt = S_REQ;
                default: w_state_nxt = r_state;
            endcase
`ifdef FETCH_MISALIGN_TRAP_EN
            if (w_redirect && (w_target_raw[1:0] != 2'b00)) begin
                w_state_nxt    = S_TRAP;
                w_misalign_nxt = 1'b1;
            end else begin
                w_misalign_nxt = r_misalign;
            end
`endif
        end else begin
            if (!stall) begin
                w_ifid_instr_nxt = NOP_INSTR;
                w_ifid_valid_nxt = 1'b0;
            end else begin
                w_ifid_valid_nxt = r_ifid_valid;
            end
            case (r_state)
                S_REQ: begin
                    if (w_granted) begin
                        w_issue_pc_nxt = r_pc;
                        w_pc_nxt       = r_pc + 32'd4;
                        w_state_nxt    = S_WAIT;
                    end else begin
                        w_state_nxt = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (!imem_rvalid) begin
                        w_state_nxt = S_WAIT;
                    end else if (r_discard) begin
                        w_discard_nxt = 1'b0;
                        w_state_nxt   = S_REQ;
                    end else if (stall) begin
                        w_hold_instr_nxt = imem_rdata;
                        w_state_nxt      = S_HOLD;
                    end else begin
                        w_ifid_instr_nxt = imem_rdata;
                        w_ifid_pc_nxt    = r_issue_pc;
                        w_ifid_pc4_nxt   = r_issue_pc + 32'd4;
                        w_ifid_valid_nxt = 1'b1;
                        w_state_nxt      = S_REQ;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        w_ifid_instr_nxt = r_hold_instr;
                        w_ifid_pc_nxt    = r_issue_pc;
                        w_ifid_pc4_nxt   = r_issue_pc + 32'd4;
                        w_ifid_valid_nxt = 1'b1;
                        w_state_nxt      = S_REQ;
                    end else begin
                        w_state_nxt = S_HOLD;
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // State registers; imem_req is registered from the next state so it is low in reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_REQ;
            r_req        <= 1'b0;
            r_pc         <= RESET_PC;
            r_issue_pc   <= 32'h0000_0000;
            r_discard    <= 1'b0;
            r_hold_instr <= NOP_INSTR;
            r_ifid_instr <= NOP_INSTR;
            r_ifid_pc    <= 32'h0000_0000;
            r_ifid_pc4   <= 32'h0000_0000;
            r_ifid_valid <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign   <= 1'b0;
`endif
        end else begin
            r_state      <= w_state_nxt;
            r_req        <= (w_state_nxt == S_REQ);
            r_pc         <= w_pc_nxt;
            r_issue_pc   <= w_issue_pc_nxt;
            r_discard    <= w_discard_nxt;
            r_hold_instr <= w_hold_instr_nxt;
            r_ifid_instr <= w_ifid_instr_nxt;
            r_ifid_pc    <= w_ifid_pc_nxt;
            r_ifid_pc4   <= w_ifid_pc4_nxt;
            r_ifid_valid <= w_ifid_valid_nxt;
`ifdef FETCH_MISALIGN_TRAP_EN
            r_misalign   <= w_misalign_nxt;
`endif
        end
    end

    assign imem_req    = r_req;
    assign imem_addr   = r_pc;
    assign IF_ID_instr = r_ifid_instr;
    assign IF_ID_pc    = r_ifid_pc;
    assign IF_ID_pc4   = r_ifid_pc4;
    assign IF_ID_valid = r_ifid_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_misalign = r_misalign;
`endif

endmodule
